// File: rtl/dpram_stream_loader.sv
// Boot-channel loader: packs a byte stream into 16-bit little-endian words and writes
// them to RAM port B, with an optional read-back pass that compares word sums.
module dpram_stream_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              verify_en,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              b_ce,
  output logic              b_we,
  output logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_write,
  input  logic [DATA_W-1:0] b_read,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       checksum
);

  // state    | meaning
  // IDLE     | waiting for start
  // LOAD_LO  | accepting the low byte of the next word
  // LOAD_HI  | accepting the high byte of the next word
  // WRITE    | word on port B, checksum/address/count update
  // VRD_ADDR | read address on port B
  // VRD_DATA | read data returned, accumulated into vsum
  // DONE     | completion pulse, err valid
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD_LO  = 3'd1;
  localparam logic [2:0] LOAD_HI  = 3'd2;
  localparam logic [2:0] WRITE    = 3'd3;
  localparam logic [2:0] VRD_ADDR = 3'd4;
  localparam logic [2:0] VRD_DATA = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   count_q;
  logic              ven;
  logic [7:0]        lo_byte;
  logic [15:0]       vsum;

  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W:0]   remaining_dec;
  logic              last_word;
  logic [15:0]       checksum_next;
  logic [15:0]       vsum_next;

  always_comb begin
    addr_inc      = addr + ADDR_ONE;
    remaining_dec = remaining - CNT_ONE;
    last_word     = (remaining <= CNT_ONE);
    checksum_next = checksum + b_write;
    vsum_next     = vsum + b_read;
  end

  assign s_ready = (state == LOAD_LO) || (state == LOAD_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      base_q    <= '0;
      remaining <= '0;
      count_q   <= '0;
      ven       <= 1'b0;
      lo_byte   <= '0;
      vsum      <= '0;
      b_ce      <= 1'b0;
      b_we      <= 1'b0;
      b_addr    <= '0;
      b_write   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      checksum  <= '0;
    end else begin
      // port B strobes and done are single-cycle unless re-asserted below
      b_ce <= 1'b0;
      b_we <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            base_q    <= base_addr;
            remaining <= word_count;
            count_q   <= word_count;
            ven       <= verify_en;
            checksum  <= '0;
            vsum      <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            if (word_count == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= LOAD_LO;
            end
          end
        end
        LOAD_LO: begin
          if (s_valid) begin
            lo_byte <= s_data;
            state   <= LOAD_HI;
          end
        end
        LOAD_HI: begin
          // port B outputs are registered so they line up with the WRITE state
          if (s_valid) begin
            b_ce    <= 1'b1;
            b_we    <= 1'b1;
            b_addr  <= addr;
            b_write <= {s_data, lo_byte};
            state   <= WRITE;
          end
        end
        WRITE: begin
          checksum  <= checksum_next;
          addr      <= addr_inc;
          remaining <= remaining_dec;
          if (!last_word) begin
            state <= LOAD_LO;
          end else if (ven) begin
            addr      <= base_q;
            remaining <= count_q;
            b_ce      <= 1'b1;
            b_addr    <= base_q;
            state     <= VRD_ADDR;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        VRD_ADDR: begin
          state <= VRD_DATA;
        end
        VRD_DATA: begin
          vsum      <= vsum_next;
          addr      <= addr_inc;
          remaining <= remaining_dec;
          if (!last_word) begin
            b_ce   <= 1'b1;
            b_addr <= addr_inc;
            state  <= VRD_ADDR;
          end else begin
            // compare including the word arriving now so err is valid alongside done
            err   <= (vsum_next != checksum);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_stream_loader.sv
// Randomized bench for dpram_stream_loader: behavioural RAM, byte-queue source and
// expected write/read/checksum/latency model derived from the loader's rules.
module tb_dpram_stream_loader;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] AMASK = '1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              verify_en;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              b_ce;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_write;
  logic [DATA_W-1:0] b_read;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       checksum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_stream_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .verify_en(verify_en), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .b_ce(b_ce), .b_we(b_we),
    .b_addr(b_addr), .b_write(b_write), .b_read(b_read), .busy(busy),
    .done(done), .err(err), .checksum(checksum)
  );

  // Registered-read RAM model; poke overwrites a word behind the loader's back.
  logic [15:0]       mem [0:(1<<ADDR_W)-1];
  logic [15:0]       rd_q;
  logic              poke_en;
  logic [ADDR_W-1:0] poke_addr;
  logic [15:0]       poke_data;

  always @(posedge clk) begin
    if (b_ce) begin
      if (b_we) mem[b_addr] <= b_write;
      else      rd_q <= mem[b_addr];
    end
    if (poke_en) mem[poke_addr] <= poke_data;
  end
  assign b_read = rd_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: s_valid always high, 1: every other cycle, 2: random
  task automatic run_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt,
                          input bit ven, input int mode, input bit corrupt);
    logic [7:0]  bytes[$];
    logic [15:0] words[$];
    logic [15:0] exp_sum;
    logic [15:0] w;
    int idx, nw, nrd, budget, exp_lat;
    bit got_done, ready_seen, want, pend, exp_err;
    bytes.delete();
    words.delete();
    exp_sum = 16'h0;
    for (int i = 0; i < 2 * int'(cnt); i++)
      bytes.push_back((mode == 0) ? 8'(i + 1) : 8'($urandom));
    for (int i = 0; i < int'(cnt); i++) begin
      w = {bytes[2*i+1], bytes[2*i]};
      words.push_back(w);
      exp_sum = exp_sum + w;
    end
    exp_err = corrupt && ven && (words[1] != 16'hFFFF);
    exp_lat = 1 + 3 * int'(cnt) + (ven ? 2 * int'(cnt) : 0);
    idx = 0; nw = 0; nrd = 0; got_done = 0; ready_seen = 0; pend = 0;
    budget = 200 + 20 * int'(cnt);

    @(negedge clk);
    base_addr = base; word_count = cnt; verify_en = ven; start = 1'b1; s_valid = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      poke_en = 1'b0;
      if (pend) begin
        poke_en = 1'b1; poke_addr = base + 1'b1; poke_data = 16'hFFFF; pend = 0;
      end
      if (cyc == 1) check_eq("busy_after_start", 32'(busy), 32'(cnt != 0 || 1'b1));
      if (b_ce && b_we) begin
        if (nw < int'(cnt)) begin
          check_eq("wr_addr", 32'(b_addr), 32'((base + ADDR_W'(nw)) & AMASK));
          check_eq("wr_data", 32'(b_write), 32'(words[nw]));
          if (corrupt && nw == 1) pend = 1;
        end else check_eq("extra_write", 32'(nw), 32'(cnt));
        nw++;
      end
      if (b_ce && !b_we) begin
        check_eq("rd_addr", 32'(b_addr), 32'((base + ADDR_W'(nrd)) & AMASK));
        nrd++;
      end
      if (s_ready) ready_seen = 1;
      if (done) begin
        got_done = 1;
        if (mode == 0) check_eq("done_latency", 32'(cyc), 32'(exp_lat));
        check_eq("checksum", 32'(checksum), 32'(exp_sum));
        check_eq("err", 32'(err), 32'(exp_err));
        // a start coinciding with the done pulse must be ignored
        start = 1'b1;
        s_valid = 1'b0;
        break;
      end
      if (cyc == 2) begin
        start = 1'b1;
        base_addr = ~base;
      end
      want = (idx < 2 * int'(cnt)) &&
             (mode == 0 || (mode == 1 && cyc % 2 == 0) || (mode == 2 && $urandom_range(1, 0) == 1));
      s_valid = want;
      s_data  = want ? bytes[idx] : 8'($urandom);
      if (want && s_ready) idx++;
    end
    if (!got_done) check_eq("done_timeout", 32'(0), 32'(1));
    s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    poke_en = 1'b0;
    check_eq("busy_after_done", 32'(busy), 32'(0));
    check_eq("done_one_cycle", 32'(done), 32'(0));
    check_eq("writes", 32'(nw), 32'(cnt));
    check_eq("bytes_consumed", 32'(idx), 32'(2 * int'(cnt)));
    check_eq("reads", 32'(nrd), ven ? 32'(cnt) : 32'(0));
    check_eq("s_ready_seen", 32'(ready_seen), 32'(cnt != 0));
    check_eq("checksum_held", 32'(checksum), 32'(exp_sum));
    check_eq("err_held", 32'(err), 32'(exp_err));
  endtask

  initial begin
    int idx;
    bit hit;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; verify_en = 1'b0;
    s_data = '0; s_valid = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready", 32'(s_ready), 0);
    check_eq("rst_b_ce", 32'(b_ce), 0);
    check_eq("rst_b_we", 32'(b_we), 0);
    check_eq("rst_b_addr", 32'(b_addr), 0);
    check_eq("rst_b_write", 32'(b_write), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_checksum", 32'(checksum), 0);
    reset = 1'b0;

    run_load(13'h0100, 14'd4, 1'b0, 0, 1'b0);
    run_load(13'h0100, 14'd4, 1'b1, 0, 1'b0);
    run_load(13'h0100, 14'd4, 1'b1, 0, 1'b1);
    run_load(13'h0100, 14'd0, 1'b1, 0, 1'b0);
    run_load(13'h1FFF, 14'd2, 1'b1, 1, 1'b0);
    for (int t = 0; t < 6; t++)
      run_load(13'($urandom), 14'($urandom_range(6, 1)), 1'($urandom), 2, 1'b0);

    // reset while the second word is in WRITE
    @(negedge clk);
    base_addr = 13'h0200; word_count = 14'd4; verify_en = 1'b0; start = 1'b1;
    idx = 0; hit = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (idx == 4) begin hit = 1; break; end
      s_valid = 1'b1;
      s_data  = 8'(idx + 8'h40);
      if (s_ready) idx++;
    end
    check_eq("reset_point_reached", 32'(hit), 1);
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_b_we", 32'(b_we), 0);
    check_eq("midrst_s_ready", 32'(s_ready), 0);
    check_eq("midrst_checksum", 32'(checksum), 0);
    reset = 1'b0;
    run_load(13'h0200, 14'd3, 1'b1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
